// File: rtl/fpdp_div_arbiter.sv
// -----------------------------------------------------------------------------
// fpdp_div_arbiter
// Shares one fpdp_division instance between NUM_REQ requesters using
// round-robin arbitration. The winning operand pair is latched and held on the
// divider inputs for the whole job. The quotient is returned to the winner as
// a one-cycle response. A watchdog aborts a job whose divider never finishes
// and returns a NaN quotient flagged by rsp_timeout.
//
// Handshake: a requester raises req_valid[i] with its operands and holds both
// until req_accept[i] pulses for one cycle (the operands are latched on that
// edge). It may withdraw req_valid before it is accepted. Exactly one
// rsp_valid[i] pulse later returns the result of every accepted request,
// unless rset intervenes.
//
// Ports:
//   clk, rset             clock, synchronous active-high reset
//   req_valid/_dividend/_divisor   per-requester request and packed operands
//   req_accept            one-hot accept pulse
//   rsp_valid/_quotient/_timeout   one-hot response pulse, quotient, abort flag
//   div_dividend/_divisor/_ready   drive the shared divider
//   div_quotient/_done    results from the shared divider
//   busy                  high whenever the sequencer is not idle
//   dbg_state             current sequencer state for debug/observation
// -----------------------------------------------------------------------------
module fpdp_div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 511
) (
  input  logic                  clk,
  input  logic                  rset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [64*NUM_REQ-1:0] req_dividend,
  input  logic [64*NUM_REQ-1:0] req_divisor,
  output logic [NUM_REQ-1:0]    req_accept,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [63:0]           rsp_quotient,
  output logic                  rsp_timeout,
  output logic [63:0]           div_dividend,
  output logic [63:0]           div_divisor,
  output logic [3:0]            div_ready,
  input  logic [63:0]           div_quotient,
  input  logic [3:0]            div_done,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [63:0] NAN_Q = 64'hFFF8_0000_0000_0000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_win;
  logic [63:0]        r_dividend;
  logic [63:0]        r_divisor;
  logic [3:0]         r_div_ready;
  logic [CNT_W-1:0]   r_cnt;
  logic [63:0]        r_quot;
  logic               r_timed_out;
  logic [NUM_REQ-1:0] r_req_accept;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [63:0]        r_rsp_quotient;
  logic               r_rsp_timeout;

  logic [IDX_W:0]     w_idx;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;

  // Scan from the highest offset down so the lowest offset from r_rr_ptr
  // (the highest-priority requester) is the last writer and wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_idx >= (IDX_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDX_W+1)'(NUM_REQ);
      end
      if (req_valid[w_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rset) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_win          <= '0;
      r_dividend     <= '0;
      r_divisor      <= '0;
      r_div_ready    <= 4'd0;
      r_cnt          <= '0;
      r_quot         <= '0;
      r_timed_out    <= 1'b0;
      r_req_accept   <= '0;
      r_rsp_valid    <= '0;
      r_rsp_quotient <= '0;
      r_rsp_timeout  <= 1'b0;
    end else begin
      r_req_accept  <= '0;
      r_rsp_valid   <= '0;
      r_rsp_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win        <= w_win;
            r_dividend   <= req_dividend[64*w_win +: 64];
            r_divisor    <= req_divisor[64*w_win +: 64];
            r_req_accept <= NUM_REQ'(1) << w_win;
            r_timed_out  <= 1'b0;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A done still high from the previous job must not be mistaken
          // for completion of this one; hold off until it clears.
          if (div_done != 4'd1) begin
            r_div_ready <= 4'd1;
            r_cnt       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (div_done == 4'd1) begin
            r_quot      <= div_quotient;
            r_div_ready <= 4'd0;
            r_state     <= S_DRAIN;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            // div_ready has now been high for TIMEOUT cycles.
            r_quot      <= NAN_Q;
            r_timed_out <= 1'b1;
            r_div_ready <= 4'd0;
            r_state     <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          // One idle cycle lets the divider fall back to its input state
          // without restarting on the old operands.
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_rsp_valid    <= NUM_REQ'(1) << r_win;
          r_rsp_quotient <= r_quot;
          r_rsp_timeout  <= r_timed_out;
          r_rr_ptr       <= (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
          r_state        <= S_IDLE;
        end
        default: begin
          r_div_ready <= 4'd0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_accept   = r_req_accept;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_quotient = r_rsp_quotient;
  assign rsp_timeout  = r_rsp_timeout;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign div_ready    = r_div_ready;
  assign busy         = (r_state != S_IDLE);
  assign dbg_state    = r_state;

endmodule
